alu_operand_stage: RTL and testbench
====================================

// Module: alu_operand_stage
// PURPOSE
//  ID/EX pipeline stage that feeds the ALU. Captures decoded operands and control, and resolves
//  RAW hazards by forwarding from EX/MEM and MEM/WB. Selects ALU operands A/B from register,
//  immediate or PC. Registers the result behind a valid/ready handshake with stall and flush.
//  Outputs drive the ALU a/b/func/sub_sra inputs directly, plus store data and writeback tags.
// PARAMETERS
//  XLEN    64  datapath width
//  RADDR_W 5   register index width
// PORTS
//  clk          in   1        clock, rising edge
//  reset        in   1        asynchronous, active-high reset
//  in_valid     in   1        decode presents a valid instruction
//  in_ready     out  1        stage can accept this cycle
//  rs1_addr     in   RADDR_W  source 1 index
//  rs2_addr     in   RADDR_W  source 2 index
//  rs1_data     in   XLEN     register-file read 1
//  rs2_data     in   XLEN     register-file read 2
//  imm          in   XLEN     sign-extended immediate
//  pc           in   XLEN     instruction PC
//  use_pc       in   1        A = pc instead of rs1 (AUIPC/JAL)
//  use_imm      in   1        B = imm instead of rs2
//  is_branch    in   1        compare op; forces sub_sra_q=1 and B=rs2
//  func         in   3        ALU function code
//  sub_sra      in   1        ALU subtract / arithmetic-shift select
//  rd_addr      in   RADDR_W  destination index
//  rd_we        in   1        destination write enable
//  exm_we       in   1        EX/MEM writes a register
//  exm_rd       in   RADDR_W  EX/MEM destination
//  exm_data     in   XLEN     EX/MEM result
//  exm_is_load  in   1        EX/MEM instruction is a load (data not yet valid)
//  mwb_we       in   1        MEM/WB writes a register
//  mwb_rd       in   RADDR_W  MEM/WB destination
//  mwb_data     in   XLEN     MEM/WB result
//  flush        in   1        kill held and incoming instruction (branch mispredict)
//  out_valid    out  1        a/b/control valid toward EX
//  out_ready    in   1        EX accepts this cycle
//  a_q          out  XLEN     ALU operand A
//  b_q          out  XLEN     ALU operand B
//  func_q       out  3        ALU func
//  sub_sra_q    out  1        ALU sub_sra
//  store_q      out  XLEN     forwarded rs2 value (store data / branch)
//  pc_q         out  XLEN     PC of held instruction
//  rd_q         out  RADDR_W  destination
//  rd_we_q      out  1        destination write enable; 0 whenever out_valid=0
//  branch_q     out  1        held instruction is a branch
// BEHAVIOUR
//  - Reset: all outputs 0, out_valid=0; asynchronous assert, synchronous-release use.
//  - Forwarding per source s (rs1/rs2): if s==0 -> 0. Else if exm_we && exm_rd==s -> exm_data.
//    Else if mwb_we && mwb_rd==s -> mwb_data. Else regfile data. EX/MEM wins over MEM/WB.
//  - Load-use: hazard = in_valid && exm_is_load && exm_we && exm_rd!=0 && exm_rd matches a
//    source actually used (rs1 unless use_pc; rs2 unless use_imm&&!is_branch, or always when
//    branch/store data is needed: treat rs2 as used when !use_imm || is_branch).
//  - in_ready = (!out_valid || out_ready) && !hazard.
//  - Capture on in_valid && in_ready: one-cycle latency, decode -> registered outputs.
//  - Operands: A = use_pc ? pc : fwd1. B = (use_imm && !is_branch) ? imm : fwd2.
//    sub_sra_q = sub_sra | is_branch.
//  - out_valid' = capture ? 1 : (out_ready ? 0 : out_valid). Held data stays stable while
//    out_valid && !out_ready.
//  - Hazard with EX free: out_valid drops to 0 (bubble); decode holds inputs.
//  - Flush (sync, highest priority): out_valid'=0, rd_we_q'=0, no capture that cycle.
//    Data registers may keep stale values.
//  - Capture and drain in the same cycle: new instruction replaces old; out_valid stays 1.
//  - Reset mid-stall: pipeline empties; forwarding state is not retained.
// STRUCTURE
//  - Shared package alu_pkg: ALU func constants FUNC_ADD=0, SLL=1, SLT=2, SLTU=3, XOR=4,
//    SRL=5, OR=6, AND=7; XLEN/RADDR_W defaults.
//  - One sub-module fwd_mux (XLEN, RADDR_W): src idx/data + two forward ports -> value.
//    Instantiated twice (rs1, rs2). Hazard logic and register bank inline.
// TESTING
//  1 Reset during out_valid=1 -> all outputs 0, out_valid=0, in_ready=1 next cycle.
//  2 exm_rd=5 data=0xAA, mwb_rd=5 data=0xBB, rs1=5 -> a_q=0xAA; rs1=0 w/ exm_rd=0 -> a_q=0.
//  3 exm_is_load, exm_rd=7, rs2=7, use_imm=0 -> in_ready=0 one cycle, bubble (out_valid=0),
//    then capture with mwb forward.
//  4 out_ready=0 for 3 cycles with out_valid=1 -> a_q/b_q/func_q stable, in_ready=0.
//  5 BEQ: is_branch=1, use_imm=1, imm=0x10, sub_sra=0 -> b_q=rs2 value, sub_sra_q=1.
//  6 flush with in_valid=1 and held instr -> out_valid=0, rd_we_q=0 next cycle; no capture.

Source files
------------

// File: rtl/alu_pkg.sv
// Shared ALU definitions: function codes and default datapath geometry.
package alu_pkg;

  localparam int XLEN_DEFAULT    = 64;
  localparam int RADDR_W_DEFAULT = 5;

  localparam logic [2:0] FUNC_ADD  = 3'd0;
  localparam logic [2:0] FUNC_SLL  = 3'd1;
  localparam logic [2:0] FUNC_SLT  = 3'd2;
  localparam logic [2:0] FUNC_SLTU = 3'd3;
  localparam logic [2:0] FUNC_XOR  = 3'd4;
  localparam logic [2:0] FUNC_SRL  = 3'd5;
  localparam logic [2:0] FUNC_OR   = 3'd6;
  localparam logic [2:0] FUNC_AND  = 3'd7;

endpackage

// File: rtl/alu_operand_stage_fwd_mux.sv
// Bypass selector for one source register: x0 reads zero, the younger EX/MEM
// result beats the older MEM/WB result, otherwise the register-file read is used.
module fwd_mux
  import alu_pkg::*;
#(
  parameter int XLEN    = XLEN_DEFAULT,
  parameter int RADDR_W = RADDR_W_DEFAULT
) (
  input  logic [RADDR_W-1:0] src_addr,
  input  logic [XLEN-1:0]    src_data,
  input  logic               exm_we,
  input  logic [RADDR_W-1:0] exm_rd,
  input  logic [XLEN-1:0]    exm_data,
  input  logic               mwb_we,
  input  logic [RADDR_W-1:0] mwb_rd,
  input  logic [XLEN-1:0]    mwb_data,
  output logic [XLEN-1:0]    fwd_data
);

  // Priority chain: zero register, then youngest in-flight write, then regfile.
  always_comb begin
    fwd_data = src_data;
    if (src_addr == {RADDR_W{1'b0}}) begin
      fwd_data = {XLEN{1'b0}};
    end else if (exm_we && (exm_rd == src_addr)) begin
      fwd_data = exm_data;
    end else if (mwb_we && (mwb_rd == src_addr)) begin
      fwd_data = mwb_data;
    end else begin
      fwd_data = src_data;
    end
  end

endmodule

// File: rtl/alu_operand_stage.sv
// ID/EX operand stage: resolves forwarding and load-use hazards, selects ALU
// operands and holds them in a single-entry valid/ready register toward EX.
module alu_operand_stage
  import alu_pkg::*;
#(
  parameter int XLEN    = XLEN_DEFAULT,
  parameter int RADDR_W = RADDR_W_DEFAULT
) (
  input  logic               clk,
  input  logic               reset,
  input  logic               in_valid,
  output logic               in_ready,
  input  logic [RADDR_W-1:0] rs1_addr,
  input  logic [RADDR_W-1:0] rs2_addr,
  input  logic [XLEN-1:0]    rs1_data,
  input  logic [XLEN-1:0]    rs2_data,
  input  logic [XLEN-1:0]    imm,
  input  logic [XLEN-1:0]    pc,
  input  logic               use_pc,
  input  logic               use_imm,
  input  logic               is_branch,
  input  logic [2:0]         func,
  input  logic               sub_sra,
  input  logic [RADDR_W-1:0] rd_addr,
  input  logic               rd_we,
  input  logic               exm_we,
  input  logic [RADDR_W-1:0] exm_rd,
  input  logic [XLEN-1:0]    exm_data,
  input  logic               exm_is_load,
  input  logic               mwb_we,
  input  logic [RADDR_W-1:0] mwb_rd,
  input  logic [XLEN-1:0]    mwb_data,
  input  logic               flush,
  output logic               out_valid,
  input  logic               out_ready,
  output logic [XLEN-1:0]    a_q,
  output logic [XLEN-1:0]    b_q,
  output logic [2:0]         func_q,
  output logic               sub_sra_q,
  output logic [XLEN-1:0]    store_q,
  output logic [XLEN-1:0]    pc_q,
  output logic [RADDR_W-1:0] rd_q,
  output logic               rd_we_q,
  output logic               branch_q
);

  logic [XLEN-1:0] fwd1_s;
  logic [XLEN-1:0] fwd2_s;
  logic [XLEN-1:0] a_s;
  logic [XLEN-1:0] b_s;
  logic            rs1_used_s;
  logic            rs2_used_s;
  logic            hazard_s;
  logic            in_ready_s;
  logic            capture_s;

  fwd_mux #(.XLEN(XLEN), .RADDR_W(RADDR_W)) u_fwd_rs1 (
    .src_addr (rs1_addr),
    .src_data (rs1_data),
    .exm_we   (exm_we),
    .exm_rd   (exm_rd),
    .exm_data (exm_data),
    .mwb_we   (mwb_we),
    .mwb_rd   (mwb_rd),
    .mwb_data (mwb_data),
    .fwd_data (fwd1_s)
  );

  fwd_mux #(.XLEN(XLEN), .RADDR_W(RADDR_W)) u_fwd_rs2 (
    .src_addr (rs2_addr),
    .src_data (rs2_data),
    .exm_we   (exm_we),
    .exm_rd   (exm_rd),
    .exm_data (exm_data),
    .mwb_we   (mwb_we),
    .mwb_rd   (mwb_rd),
    .mwb_data (mwb_data),
    .fwd_data (fwd2_s)
  );

  // Load-use detection: a load in EX/MEM has no data yet, so a dependent
  // instruction must wait. rs2 counts as used for branches and stores too.
  always_comb begin
    rs1_used_s = !use_pc;
    rs2_used_s = !use_imm || is_branch;
    hazard_s   = 1'b0;
    if (in_valid && exm_is_load && exm_we && (exm_rd != {RADDR_W{1'b0}})) begin
      hazard_s = (rs1_used_s && (exm_rd == rs1_addr)) ||
                 (rs2_used_s && (exm_rd == rs2_addr));
    end else begin
      hazard_s = 1'b0;
    end
    in_ready_s = (!out_valid || out_ready) && !hazard_s;
    capture_s  = in_valid && in_ready_s && !flush;
  end

  // Operand selection: PC for AUIPC/JAL, immediate unless this is a compare.
  always_comb begin
    a_s = fwd1_s;
    b_s = fwd2_s;
    if (use_pc) begin
      a_s = pc;
    end else begin
      a_s = fwd1_s;
    end
    if (use_imm && !is_branch) begin
      b_s = imm;
    end else begin
      b_s = fwd2_s;
    end
  end

  assign in_ready = in_ready_s;

  // Output register bank: flush kills, capture replaces, drain empties, stall holds.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      out_valid <= 1'b0;
      a_q       <= {XLEN{1'b0}};
      b_q       <= {XLEN{1'b0}};
      func_q    <= 3'd0;
      sub_sra_q <= 1'b0;
      store_q   <= {XLEN{1'b0}};
      pc_q      <= {XLEN{1'b0}};
      rd_q      <= {RADDR_W{1'b0}};
      rd_we_q   <= 1'b0;
      branch_q  <= 1'b0;
    end else if (flush) begin
      out_valid <= 1'b0;
      rd_we_q   <= 1'b0;
    end else if (capture_s) begin
      out_valid <= 1'b1;
      a_q       <= a_s;
      b_q       <= b_s;
      func_q    <= func;
      sub_sra_q <= sub_sra | is_branch;
      store_q   <= fwd2_s;
      pc_q      <= pc;
      rd_q      <= rd_addr;
      rd_we_q   <= rd_we;
      branch_q  <= is_branch;
    end else if (out_ready) begin
      out_valid <= 1'b0;
      rd_we_q   <= 1'b0;
    end else begin
      out_valid <= out_valid;
      rd_we_q   <= rd_we_q;
    end
  end

endmodule

// File: tb/tb_alu_operand_stage.sv
// Scoreboard bench for alu_operand_stage: directed scenarios then random traffic.
module tb_alu_operand_stage;
  import alu_pkg::*;

  logic        clk = 1'b0;
  logic        reset;
  logic        in_valid, in_ready;
  logic [4:0]  rs1_addr, rs2_addr, rd_addr, exm_rd, mwb_rd;
  logic [63:0] rs1_data, rs2_data, imm, pc, exm_data, mwb_data;
  logic        use_pc, use_imm, is_branch, sub_sra, rd_we;
  logic [2:0]  func;
  logic        exm_we, exm_is_load, mwb_we, flush;
  logic        out_valid, out_ready;
  logic [63:0] a_q, b_q, store_q, pc_q;
  logic [2:0]  func_q;
  logic        sub_sra_q, rd_we_q, branch_q;
  logic [4:0]  rd_q;

  typedef struct {
    logic [63:0] a, b, store, pc;
    logic [2:0]  func;
    logic        sub_sra, rd_we, branch;
    logic [4:0]  rd;
  } exp_t;

  exp_t exp_q[$];
  int   checks = 0;
  int   failures = 0;
  int   kill_n = 0;
  logic model_valid = 1'b0;

  always #5 clk = ~clk;

  alu_operand_stage dut (
    .clk(clk), .reset(reset), .in_valid(in_valid), .in_ready(in_ready),
    .rs1_addr(rs1_addr), .rs2_addr(rs2_addr), .rs1_data(rs1_data), .rs2_data(rs2_data),
    .imm(imm), .pc(pc), .use_pc(use_pc), .use_imm(use_imm), .is_branch(is_branch),
    .func(func), .sub_sra(sub_sra), .rd_addr(rd_addr), .rd_we(rd_we),
    .exm_we(exm_we), .exm_rd(exm_rd), .exm_data(exm_data), .exm_is_load(exm_is_load),
    .mwb_we(mwb_we), .mwb_rd(mwb_rd), .mwb_data(mwb_data), .flush(flush),
    .out_valid(out_valid), .out_ready(out_ready), .a_q(a_q), .b_q(b_q),
    .func_q(func_q), .sub_sra_q(sub_sra_q), .store_q(store_q), .pc_q(pc_q),
    .rd_q(rd_q), .rd_we_q(rd_we_q), .branch_q(branch_q)
  );

  task automatic chk(input string nm, input logic [63:0] act, input logic [63:0] req);
    checks++;
    if (act !== req) begin
      failures++;
      $display("FAIL %s actual=%h required=%h", nm, act, req);
    end
  endtask

  // Architectural value of a source: x0 is zero, the youngest pending write wins.
  function automatic logic [63:0] src_value(input logic [4:0] s, input logic [63:0] rf);
    logic [63:0] v;
    v = rf;
    if (s == 5'd0) v = 64'd0;
    else if (exm_we && exm_rd == s) v = exm_data;
    else if (mwb_we && mwb_rd == s) v = mwb_data;
    return v;
  endfunction

  // Monitor: whenever the stage presents data, compare with the oldest expectation.
  always @(negedge clk) begin : mon
    exp_t e;
    if (reset === 1'b0 && out_valid === 1'b1) begin
      if (exp_q.size() == 0) begin
        checks++;
        failures++;
        $display("FAIL unexpected_out_valid actual=1 required=0");
      end else begin
        e = exp_q[0];
        chk("a_q", a_q, e.a);
        chk("b_q", b_q, e.b);
        chk("func_q", {61'd0, func_q}, {61'd0, e.func});
        chk("sub_sra_q", {63'd0, sub_sra_q}, {63'd0, e.sub_sra});
        chk("store_q", store_q, e.store);
        chk("pc_q", pc_q, e.pc);
        chk("rd_q", {59'd0, rd_q}, {59'd0, e.rd});
        chk("rd_we_q", {63'd0, rd_we_q}, {63'd0, e.rd_we});
        chk("branch_q", {63'd0, branch_q}, {63'd0, e.branch});
        if (out_ready) void'(exp_q.pop_front());
      end
    end
  end

  // One clock of stimulus: called just after a rising edge with inputs already set.
  task automatic drive_cycle(output logic cap);
    logic hz, rdy;
    exp_t e;
    while (kill_n > 0) begin
      void'(exp_q.pop_front());
      kill_n--;
    end
    chk("out_valid", {63'd0, out_valid}, {63'd0, model_valid});
    if (!model_valid) chk("rd_we_idle", {63'd0, rd_we_q}, 64'd0);
    #1;
    hz = in_valid && exm_is_load && exm_we && exm_rd != 5'd0 &&
         ((!use_pc && exm_rd == rs1_addr) || ((!use_imm || is_branch) && exm_rd == rs2_addr));
    rdy = (!model_valid || out_ready) && !hz;
    chk("in_ready", {63'd0, in_ready}, {63'd0, rdy});
    cap = in_valid && rdy && !flush;
    if (flush) begin
      kill_n = exp_q.size();
    end else if (cap) begin
      e.a       = use_pc ? pc : src_value(rs1_addr, rs1_data);
      e.b       = (use_imm && !is_branch) ? imm : src_value(rs2_addr, rs2_data);
      e.store   = src_value(rs2_addr, rs2_data);
      e.pc      = pc;
      e.func    = func;
      e.sub_sra = sub_sra | is_branch;
      e.rd      = rd_addr;
      e.rd_we   = rd_we;
      e.branch  = is_branch;
      exp_q.push_back(e);
    end
    if (flush) model_valid = 1'b0;
    else if (cap) model_valid = 1'b1;
    else if (out_ready) model_valid = 1'b0;
    @(posedge clk);
    #1;
  endtask

  task automatic clear_inputs();
    in_valid = 1'b0; rs1_addr = 5'd0; rs2_addr = 5'd0; rd_addr = 5'd0;
    rs1_data = 64'd0; rs2_data = 64'd0; imm = 64'd0; pc = 64'd0;
    use_pc = 1'b0; use_imm = 1'b0; is_branch = 1'b0; sub_sra = 1'b0; rd_we = 1'b0;
    func = FUNC_ADD; exm_we = 1'b0; exm_rd = 5'd0; exm_data = 64'd0; exm_is_load = 1'b0;
    mwb_we = 1'b0; mwb_rd = 5'd0; mwb_data = 64'd0; flush = 1'b0; out_ready = 1'b1;
  endtask

  task automatic chk_outputs_zero(input string tag);
    chk({tag, "_out_valid"}, {63'd0, out_valid}, 64'd0);
    chk({tag, "_a_q"}, a_q, 64'd0);
    chk({tag, "_b_q"}, b_q, 64'd0);
    chk({tag, "_store_q"}, store_q, 64'd0);
    chk({tag, "_ctrl"}, {48'd0, func_q, sub_sra_q, rd_q, rd_we_q, branch_q, pc_q[4:0]}, 64'd0);
  endtask

  initial begin : stim
    logic cap, hold;
    clear_inputs();
    reset = 1'b1;
    repeat (2) @(posedge clk);
    #1;
    chk_outputs_zero("reset");
    reset = 1'b0;

    // Forwarding priority: EX/MEM beats MEM/WB; x0 never forwards.
    in_valid = 1'b1; rs1_addr = 5'd5; rs1_data = 64'h11; rd_addr = 5'd9; rd_we = 1'b1;
    exm_we = 1'b1; exm_rd = 5'd5; exm_data = 64'hAA;
    mwb_we = 1'b1; mwb_rd = 5'd5; mwb_data = 64'hBB;
    drive_cycle(cap);
    chk("fwd_exm_priority", a_q, 64'hAA);
    rs1_addr = 5'd0; exm_rd = 5'd0; mwb_rd = 5'd0;
    drive_cycle(cap);
    chk("fwd_x0_zero", a_q, 64'd0);

    // Load-use: stall one cycle, bubble, then capture with the MEM/WB value.
    rs1_addr = 5'd1; rs1_data = 64'h1234; rs2_addr = 5'd7; rs2_data = 64'h11;
    exm_we = 1'b1; exm_rd = 5'd7; exm_is_load = 1'b1; mwb_we = 1'b0;
    #1;
    chk("load_use_in_ready", {63'd0, in_ready}, 64'd0);
    drive_cycle(cap);
    chk("load_use_bubble", {63'd0, out_valid}, 64'd0);
    exm_we = 1'b0; exm_is_load = 1'b0; mwb_we = 1'b1; mwb_rd = 5'd7; mwb_data = 64'h77;
    drive_cycle(cap);
    chk("load_use_b_fwd", b_q, 64'h77);

    // EX back-pressure: held operands stay put and decode is blocked.
    in_valid = 1'b0; out_ready = 1'b0; mwb_we = 1'b0;
    for (int i = 0; i < 3; i++) begin
      drive_cycle(cap);
      chk("stall_a_stable", a_q, 64'h1234);
      chk("stall_in_ready", {63'd0, in_ready}, 64'd0);
    end

    // Branch compare: B comes from rs2 despite use_imm, subtract forced.
    out_ready = 1'b1; in_valid = 1'b1; is_branch = 1'b1; use_imm = 1'b1; imm = 64'h10;
    sub_sra = 1'b0; rs2_addr = 5'd3; rs2_data = 64'h55; rd_we = 1'b0; func = FUNC_SLT;
    drive_cycle(cap);
    chk("beq_b_q", b_q, 64'h55);
    chk("beq_sub_sra_q", {63'd0, sub_sra_q}, 64'd1);

    // Flush kills the held branch and the incoming instruction.
    out_ready = 1'b0; is_branch = 1'b0; use_imm = 1'b0; rd_we = 1'b1; flush = 1'b1;
    drive_cycle(cap);
    chk("flush_out_valid", {63'd0, out_valid}, 64'd0);
    chk("flush_rd_we_q", {63'd0, rd_we_q}, 64'd0);
    flush = 1'b0; in_valid = 1'b0; out_ready = 1'b1;
    drive_cycle(cap);

    // Reset while an instruction is held under back-pressure.
    in_valid = 1'b1; out_ready = 1'b0; rs1_addr = 5'd2; rs1_data = 64'hCAFE;
    drive_cycle(cap);
    reset = 1'b1;
    #2;
    chk_outputs_zero("midreset");
    exp_q.delete();
    kill_n = 0;
    model_valid = 1'b0;
    @(posedge clk);
    #1;
    reset = 1'b0; in_valid = 1'b0;
    #1;
    chk("midreset_in_ready", {63'd0, in_ready}, 64'd1);
    @(posedge clk);
    #1;

    // Random traffic with a small register namespace to provoke forwarding hits.
    hold = 1'b0;
    for (int i = 0; i < 400; i++) begin
      if (!hold) begin
        in_valid  = ($urandom_range(0, 9) < 7);
        rs1_addr  = 5'($urandom_range(0, 7));
        rs2_addr  = 5'($urandom_range(0, 7));
        rd_addr   = 5'($urandom_range(0, 31));
        rs1_data  = {$urandom, $urandom};
        rs2_data  = {$urandom, $urandom};
        imm       = {$urandom, $urandom};
        pc        = {$urandom, $urandom};
        use_pc    = ($urandom_range(0, 3) == 0);
        use_imm   = $urandom_range(0, 1) == 1;
        is_branch = ($urandom_range(0, 4) == 0);
        func      = 3'($urandom_range(0, 7));
        sub_sra   = $urandom_range(0, 1) == 1;
        rd_we     = $urandom_range(0, 1) == 1;
      end
      exm_we      = $urandom_range(0, 1) == 1;
      exm_rd      = 5'($urandom_range(0, 7));
      exm_data    = {$urandom, $urandom};
      exm_is_load = ($urandom_range(0, 3) == 0);
      mwb_we      = $urandom_range(0, 1) == 1;
      mwb_rd      = 5'($urandom_range(0, 7));
      mwb_data    = {$urandom, $urandom};
      out_ready   = ($urandom_range(0, 9) < 7);
      flush       = ($urandom_range(0, 19) == 0);
      if (flush) out_ready = 1'b0;
      drive_cycle(cap);
      hold = in_valid && !cap && !flush;
    end

    // Drain and confirm every expected instruction was presented.
    clear_inputs();
    repeat (3) drive_cycle(cap);
    chk("scoreboard_empty", 64'(exp_q.size()), 64'd0);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
